// File: rtl/instr_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_stage_pkg
// Purpose  : Shared ISA definitions for the 16-bit pipeline. Holds the opcode
//            encodings, the NOP instruction word and the fetch FSM state
//            encodings. The control decoder imports the same package.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_stage_pkg;

  // Opcode field = instr[INSTR_WIDTH-1 -: 4]
  localparam logic [3:0] OP_LW    = 4'b0000;
  localparam logic [3:0] OP_SW    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MOV   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_JMPZ  = 4'b0101;
  localparam logic [3:0] OP_STOP  = 4'b0111;
  localparam logic [3:0] OP_ADDF  = 4'b1000;
  localparam logic [3:0] OP_MULTF = 4'b1001;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  localparam logic [15:0] NOP_INSTR = 16'hF000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_stop(input logic [3:0] opcode);
    return (opcode == OP_STOP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline latch (instruction, PC+1, valid) with flush and
//            hold controls. Flush wins over hold; flush loads a NOP bubble.
// Ports    : clk, rst_n        - clock, async active-low reset
//            flush_i           - load NOP bubble (valid=0, pc=0)
//            hold_i            - keep all three fields unchanged
//            instr_i, pc_i     - next instruction word and its PC+1
//            instr_o, pc_o, valid_o - latched contents
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
  import instr_fetch_stage_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   hold_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [ADDR_WIDTH-1:0]  pc_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic                   valid_o
);

  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = {OP_NOP, {(INSTR_WIDTH-4){1'b0}}};

  logic [INSTR_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic                   r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_WORD;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (flush_i) begin
      r_instr <= NOP_WORD;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (!hold_i) begin
      r_instr <= instr_i;
      r_pc    <= pc_i;
      r_valid <= 1'b1;
    end
  end

  assign instr_o = r_instr;
  assign pc_o    = r_pc;
  assign valid_o = r_valid;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_stage
// Purpose  : IF stage. Owns the PC and fetch FSM (IDLE/RUN/HALT), drives the
//            instruction-memory address and fills the IF/ID latch. Handles
//            hazard stalls, branch redirects with flush, and STOP halting.
// Ports    : clk, rst_n                - clock, async active-low reset
//            start_i                   - leave IDLE, begin fetching at RESET_PC
//            stall_i                   - hold PC and IF/ID
//            redirect_i, redirect_pc_i - taken branch/jump and its target
//            imem_addr_o, imem_rdata_i - instruction memory (combinational read)
//            if_id_instr_o, if_id_pc_o, if_id_valid_o - IF/ID latch
//            halted_o                  - high while in HALT
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    INSTR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [INSTR_WIDTH-1:0] if_id_instr_o,
  output logic [ADDR_WIDTH-1:0]  if_id_pc_o,
  output logic                   if_id_valid_o,
  output logic                   halted_o
);

  fetch_state_t          r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_halted;

  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic                  w_stop_seen;
  logic                  w_flush;
  logic                  w_run;

  // Wraps modulo 2^ADDR_WIDTH by construction
  assign w_pc_inc    = r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign w_run       = (r_state == ST_RUN);
  assign w_stop_seen = w_run && if_id_valid_o && is_stop(if_id_instr_o[INSTR_WIDTH-1 -: 4]);

  // Bubble the latch outside RUN, on redirect, and behind a STOP so the word
  // fetched after it never reaches the decoder.
  assign w_flush = !w_run || redirect_i || w_stop_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
          end
        end
        ST_RUN: begin
          if (redirect_i) begin
            r_pc <= redirect_pc_i;
          end else begin
            if (w_stop_seen) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end
            if (!stall_i) begin
              r_pc <= w_pc_inc;
            end
          end
        end
        ST_HALT: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  if_id_reg #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (w_flush),
    .hold_i  (stall_i),
    .instr_i (imem_rdata_i),
    .pc_i    (w_pc_inc),
    .instr_o (if_id_instr_o),
    .pc_o    (if_id_pc_o),
    .valid_o (if_id_valid_o)
  );

  assign imem_addr_o = r_pc;
  assign halted_o    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_stage
// Purpose  : Directed self-checking bench for instr_fetch_stage. Instance A
//            uses RESET_PC=0, instance B uses RESET_PC=16'hFFFE for the wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Instance A
  logic        rst_n, start, stall, redirect;
  logic [15:0] redirect_pc, imem_addr, imem_rdata, if_id_instr, if_id_pc;
  logic        if_id_valid, halted;
  logic [15:0] mem [0:255];

  // Instance B
  logic        rst_n_b, start_b, stall_b, redirect_b;
  logic [15:0] redirect_pc_b, imem_addr_b, imem_rdata_b, if_id_instr_b, if_id_pc_b;
  logic        if_id_valid_b, halted_b;

  always #5 clk = ~clk;

  assign imem_rdata   = mem[imem_addr[7:0]];
  assign imem_rdata_b = {4'h2, imem_addr_b[11:0]};

  instr_fetch_stage #(
    .ADDR_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(16'h0000)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stall_i(stall),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .if_id_instr_o(if_id_instr), .if_id_pc_o(if_id_pc),
    .if_id_valid_o(if_id_valid), .halted_o(halted)
  );

  instr_fetch_stage #(
    .ADDR_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(16'hFFFE)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .start_i(start_b), .stall_i(stall_b),
    .redirect_i(redirect_b), .redirect_pc_i(redirect_pc_b),
    .imem_addr_o(imem_addr_b), .imem_rdata_i(imem_rdata_b),
    .if_id_instr_o(if_id_instr_b), .if_id_pc_o(if_id_pc_b),
    .if_id_valid_o(if_id_valid_b), .halted_o(halted_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [15:0] addr, input logic [15:0] instr,
                       input logic [15:0] pc, input logic valid, input logic hlt);
    chk({tag, ".addr"},   32'(imem_addr),   32'(addr));
    chk({tag, ".instr"},  32'(if_id_instr), 32'(instr));
    chk({tag, ".pc"},     32'(if_id_pc),    32'(pc));
    chk({tag, ".valid"},  32'(if_id_valid), 32'(valid));
    chk({tag, ".halted"}, 32'(halted),      32'(hlt));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h2000 | 16'(i);
    mem[8'h42] = 16'h7000;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    rst_n_b = 1'b0; start_b = 1'b0; stall_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = 16'h0;

    // Reset state
    step(); step();
    chk_a("reset", 16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_a("idle", 16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b0);

    // Start and sequential fetch
    start = 1'b1;
    step();
    start = 1'b0;
    chk_a("start", 16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b0);
    step(); chk_a("fetch0", 16'h0001, 16'h2000, 16'h0001, 1'b1, 1'b0);
    step(); chk_a("fetch1", 16'h0002, 16'h2001, 16'h0002, 1'b1, 1'b0);
    step(); chk_a("fetch2", 16'h0003, 16'h2002, 16'h0003, 1'b1, 1'b0);
    step(); chk_a("fetch3", 16'h0004, 16'h2003, 16'h0004, 1'b1, 1'b0);
    step(); chk_a("fetch4", 16'h0005, 16'h2004, 16'h0005, 1'b1, 1'b0);

    // Three-cycle stall at PC=5
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); chk_a("stall", 16'h0005, 16'h2004, 16'h0005, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step(); chk_a("unstall", 16'h0006, 16'h2005, 16'h0006, 1'b1, 1'b0);

    // Redirect overrides concurrent stall
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    stall = 1'b0; redirect = 1'b0;
    chk_a("redir", 16'h0040, 16'hF000, 16'h0000, 1'b0, 1'b0);
    step(); chk_a("redir_fetch", 16'h0041, 16'h2040, 16'h0041, 1'b1, 1'b0);
    step(); chk_a("pre_stop", 16'h0042, 16'h2041, 16'h0042, 1'b1, 1'b0);
    step(); chk_a("stop_in_ifid", 16'h0043, 16'h7000, 16'h0043, 1'b1, 1'b0);

    // Redirect in the same cycle as STOP cancels the halt
    redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    chk_a("stop_redir", 16'h0010, 16'hF000, 16'h0000, 1'b0, 1'b0);
    step(); chk_a("stop_redir_fetch", 16'h0011, 16'h2010, 16'h0011, 1'b1, 1'b0);

    // Async reset mid-run, then STOP at addr 3
    #2 rst_n = 1'b0;
    #1 chk_a("async_rst_a", 16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b0);
    mem[8'h03] = 16'h7000;
    step();
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); chk_a("s_fetch0", 16'h0001, 16'h2000, 16'h0001, 1'b1, 1'b0);
    step(); chk_a("s_fetch1", 16'h0002, 16'h2001, 16'h0002, 1'b1, 1'b0);
    step(); chk_a("s_fetch2", 16'h0003, 16'h2002, 16'h0003, 1'b1, 1'b0);
    step(); chk_a("s_stop", 16'h0004, 16'h7000, 16'h0004, 1'b1, 1'b0);
    step(); chk_a("halt0", 16'h0005, 16'hF000, 16'h0000, 1'b0, 1'b1);
    step(); chk_a("halt1", 16'h0005, 16'hF000, 16'h0000, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); chk_a("halt_start_ign", 16'h0005, 16'hF000, 16'h0000, 1'b0, 1'b1);

    // Instance B: PC wrap from 16'hFFFE
    rst_n_b = 1'b1;
    step();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("wrap.addr0", 32'(imem_addr_b), 32'h0000_FFFE);
    step();
    chk("wrap.addr1", 32'(imem_addr_b), 32'h0000_FFFF);
    chk("wrap.pc1",   32'(if_id_pc_b),  32'h0000_FFFF);
    chk("wrap.ins1",  32'(if_id_instr_b), 32'h0000_2FFE);
    step();
    chk("wrap.addr2", 32'(imem_addr_b), 32'h0000_0000);
    chk("wrap.pc2",   32'(if_id_pc_b),  32'h0000_0000);
    chk("wrap.val2",  32'(if_id_valid_b), 32'h1);
    step();
    chk("wrap.addr3", 32'(imem_addr_b), 32'h0000_0001);
    chk("wrap.pc3",   32'(if_id_pc_b),  32'h0000_0001);

    // Reset asserted mid-stall takes effect without waiting for a clock
    stall_b = 1'b1;
    step();
    chk("wrap.stall_addr", 32'(imem_addr_b), 32'h0000_0001);
    #2 rst_n_b = 1'b0;
    #1;
    chk("b_rst.addr",   32'(imem_addr_b),   32'h0000_FFFE);
    chk("b_rst.instr",  32'(if_id_instr_b), 32'h0000_F000);
    chk("b_rst.pc",     32'(if_id_pc_b),    32'h0);
    chk("b_rst.valid",  32'(if_id_valid_b), 32'h0);
    chk("b_rst.halted", 32'(halted_b),      32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
